// File: rtl/dm_bank.sv
// Byte-addressed little-endian data RAM with req/ready/rvalid handshake,
// one-cycle registered read, address exceptions and a post-reset clear pass.
module dm_bank #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  dm_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_B  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_next;
  logic [IW-1:0] clr_idx;
  logic clearing;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_idx <= clr_idx + IW'(1);
    end
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_idx == LAST_IDX) state_next = IDLE;
  end

  always_comb begin
    ready    = (state == IDLE);
    clearing = (state == CLEAR);
  end

  // Request decode
  logic [31:0]   off;
  logic [1:0]    lane;
  logic [IW-1:0] idx;
  logic          in_range, misalign, reserved_op, unsigned_store, exc, accept;
  logic [3:0]    st_be;
  logic [31:0]   st_word;

  always_comb begin
    off         = addr - BASE_ADDR;
    lane        = off[1:0];
    idx         = off[IW+1:2];
    in_range    = ((off >> (IW + 2)) == 32'd0);
    misalign    = 1'b0;
    reserved_op = 1'b0;
    st_be       = 4'b0000;
    st_word     = wdata;
    case (dm_op)
      OP_W:        begin misalign = (lane != 2'b00); st_be = 4'b1111; end
      OP_H, OP_HU: begin
        misalign = off[0];
        st_be    = off[1] ? 4'b1100 : 4'b0011;
        st_word  = {2{wdata[15:0]}};
      end
      OP_B, OP_BU: begin
        st_be   = 4'b0001 << lane;
        st_word = {4{wdata[7:0]}};
      end
      default:     reserved_op = 1'b1;
    endcase
    unsigned_store = we && (dm_op == OP_HU || dm_op == OP_BU);
    exc            = !in_range || misalign || reserved_op || unsigned_store;
    accept         = ready && req;
  end

  // The clear pass shares the write port with stores
  logic [3:0]    wr_be;
  logic [IW-1:0] wr_idx;
  logic [31:0]   wr_word;
  logic          rd_en;
  logic [31:0]   ram_q;

  always_comb begin
    wr_be   = clearing ? 4'b1111 : ((accept && we && !exc) ? st_be : 4'b0000);
    wr_idx  = clearing ? clr_idx : idx;
    wr_word = clearing ? 32'd0 : st_word;
    rd_en   = accept && !we && !exc;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q;
      always_ff @(posedge clk) begin
        if (wr_be[gi]) mem[wr_idx] <= wr_word[8*gi +: 8];
        if (rd_en)     q <= mem[idx];
      end
      assign ram_q[8*gi +: 8] = q;
    end
  endgenerate

  // Response pipeline
  logic       rvalid_reg, exc_reg, we_reg;
  logic [2:0] op_reg;
  logic [1:0] lane_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_reg <= 1'b0;
      exc_reg    <= 1'b0;
      we_reg     <= 1'b0;
      op_reg     <= 3'b000;
      lane_reg   <= 2'b00;
    end else begin
      rvalid_reg <= accept;
      if (accept) begin
        exc_reg  <= exc;
        we_reg   <= we;
        op_reg   <= dm_op;
        lane_reg <= lane;
      end
    end
  end

  logic [15:0] half;
  logic [7:0]  byte_val;
  logic [31:0] ext;

  always_comb begin
    half     = lane_reg[1] ? ram_q[31:16] : ram_q[15:0];
    byte_val = ram_q[8*lane_reg +: 8];
    case (op_reg)
      OP_H:    ext = {{16{half[15]}}, half};
      OP_HU:   ext = {16'd0, half};
      OP_B:    ext = {{24{byte_val[7]}}, byte_val};
      OP_BU:   ext = {24'd0, byte_val};
      default: ext = ram_q;
    endcase
    rvalid   = rvalid_reg;
    rdata    = (rvalid_reg && !exc_reg && !we_reg) ? ext : 32'd0;
    exc_adel = rvalid_reg && exc_reg && !we_reg;
    exc_ades = rvalid_reg && exc_reg && we_reg;
  end
endmodule

// File: doc/dm_bank.md
Name: dm_bank

Overview:
- Parametrised successor to the single-cycle data memory. Byte-addressed, little-endian, 32-bit data RAM with a req/ready/rvalid handshake and registered 1-cycle read latency.
- Supports W, H, HU, B, BU loads and W, H, B stores with byte-enable writes. Signed and zero extension on loads.
- Raises load/store address exceptions on misaligned, out-of-range or reserved accesses.
- Contains a post-reset clear FSM that zeroes the array. Sits in the MEM stage of the pipelined CPU.

Parameters:
- DEPTH, 1024: number of 32-bit words. Power of two, ≥ 2. Index width is IW = $clog2(DEPTH).
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be word-aligned.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  1  access request, sampled only when ready=1.
- we  in  1  1 = store, 0 = load.
- dm_op  in  3  000 W, 001 H, 010 HU, 011 B, 100 BU; 101–111 reserved. HU/BU are valid for loads only.
- addr  in  32  byte address.
- wdata  in  32  store data; the low 8/16/32 bits are used.
- ready  out  1  block can accept a request this cycle.
- rvalid  out  1  one-cycle response pulse, one per accepted request.
- rdata  out  32  extended load data, valid with rvalid. 0 for stores and for excepted loads.
- exc_adel  out  1  load address exception, valid with rvalid.
- exc_ades  out  1  store address exception, valid with rvalid.

Behaviour:
- Reset asserted (reset=0), asynchronous: state←CLEAR, clr_idx←0, ready←0, rvalid←0, rdata←0, exc_adel←0, exc_ades←0. The array itself is not reset asynchronously.
- CLEAR state: writes 0 to word clr_idx each cycle, then clr_idx+1. When the write to word DEPTH-1 completes, the next state is IDLE. This takes exactly DEPTH cycles after reset deasserts. ready=0 throughout; req is ignored.
- Reset during CLEAR restarts the clear from index 0.
- IDLE state: ready=1. A request is accepted at a rising edge where req=1. Exactly one access per cycle; back-to-back accesses run at full throughput.
- Response timing: the cycle after acceptance, rvalid=1 together with rdata/exc. If no request was accepted, rvalid=0, rdata=0 and both exc flags are 0 the next cycle.
- Offset computation: off = addr − BASE_ADDR (32-bit). The access is in range iff off < DEPTH*4. Word index = off[IW+1:2]; byte lane = off[1:0].
- Exception conditions (any one suffices):
  - out of range;
  - W with off[1:0]≠0;
  - H/HU with off[0]≠0;
  - reserved dm_op;
  - HU/BU with we=1.
- On an exception: no array write. rdata=0. exc_adel=~we, exc_ades=we.
- Store data placement:
  - W: writes all 4 bytes.
  - H: writes wdata[15:0] to bytes {lane+1, lane}.
  - B: writes wdata[7:0] to byte lane.
  - Other bytes in the word are untouched.
- Load extraction from the word:
  - W: whole word.
  - H/HU: bits[16*off[1]+:16], sign- or zero-extended.
  - B/BU: bits[8*lane+:8], sign- or zero-extended.
- Ordering: a load accepted the cycle after a store to the same word returns the post-store value; write-first order applies.
- Store response: rvalid=1, rdata=0, no exception flag set (unless the store excepted).

Test Plan:
1. Reset low for 2 cycles, then high with DEPTH=1024 → ready=0 for exactly 1024 cycles, then 1. A lw at 12 then returns 0. Pulsing reset at clear cycle 500 → ready rises exactly 1024 cycles after the second release.
2. sw 32'd998244353 at addr 12, then sw 32'd19260817 at 1020, then lw 12 and lw 1020 → rdata 0x3B800001, then 0x0125E591. Each response arrives 1 cycle after acceptance; rvalid pulses for all 4 requests.
3. After scenario 2: sb wdata=88888 at 13, then lw 12 → 0x3B803801. Then:
   - lh 12 → 0x00003801;
   - lb 15 → 0x0000003B;
   - lh 1022 → 0x00000125;
   - lb 1021 → 0xFFFFFFE5;
   - lbu 1021 → 0x000000E5.
4. sw 0xDEADBEEF at 14 → rvalid=1, exc_ades=1. A following lw 12 returns an unchanged word. lh 13 → exc_adel=1, rdata=0. lw 4096 (out of range) → exc_adel=1. dm_op=3'b110 → exception flag set.
5. Hold req=1 continuously: sh 0xABCD at 2, then lhu 2, then lh 2 → rdata 0x0000ABCD, then 0xFFFFABCD. No idle cycles between the two responses.
6. BASE_ADDR=32'h0000_3000, DEPTH=16: sw at 0x3000 and 0x303C succeed. Accesses at 0x2FFC and 0x3040 raise exceptions.
